// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write-back entry type and zero-register constant.
package wb_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] wreg;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order circular buffer of pending writes; per-entry valid flags
// and register fields are exposed so the owner can check for hazards.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int AW    = ADDR_W_DEF,
    parameter int W     = DATA_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [AW-1:0]           push_reg,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [AW-1:0]           head_reg,
    output logic [W-1:0]            head_data,
    output logic [DEPTH-1:0]        ent_valid,
    output logic [DEPTH*AW-1:0]     ent_regs,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [AW-1:0]    reg_q  [DEPTH];
    logic [AW-1:0]    reg_d  [DEPTH];
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    always_comb begin
        reg_d   = reg_q;
        data_d  = data_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (pop) begin
            valid_d[rd_q] = 1'b0;
            rd_d          = rd_q + 1'b1;
        end
        if (push) begin
            reg_d[wr_q]   = push_reg;
            data_d[wr_q]  = push_data;
            valid_d[wr_q] = 1'b1;
            wr_d          = wr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        reg_q  <= reg_d;
        data_q <= data_d;
        if (rst) begin
            valid_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_regs
        assign ent_regs[i*AW +: AW] = reg_q[i];
    end
    assign head_reg  = reg_q[rd_q];
    assign head_data = data_q[rd_q];
    assign ent_valid = valid_q;
    assign count     = count_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU and long-latency result streams onto the
// single register-file write port and reports hazards on still-pending writes.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int width     = DATA_W_DEF,
    parameter int AddrWidth = ADDR_W_DEF,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src0_valid,
    input  logic [AddrWidth-1:0]   src0_reg,
    input  logic [width-1:0]       src0_data,
    input  logic                   src1_valid,
    output logic                   src1_ready,
    input  logic [AddrWidth-1:0]   src1_reg,
    input  logic [width-1:0]       src1_data,
    output logic                   RegWrite,
    output logic [AddrWidth-1:0]   writeReg,
    output logic [width-1:0]       writeData,
    input  logic [AddrWidth-1:0]   chk_reg_a,
    input  logic [AddrWidth-1:0]   chk_reg_b,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic [$clog2(DEPTH):0] pend_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AddrWidth-1:0] ZERO = AddrWidth'(REG_ZERO);
    logic                   reg_write_q, reg_write_d;
    logic [AddrWidth-1:0]   write_reg_q, write_reg_d;
    logic [width-1:0]       write_data_q, write_data_d;
    logic                   push, pop, bypass, empty;
    logic [AddrWidth-1:0]   head_reg, sel_reg;
    logic [width-1:0]       head_data, sel_data;
    logic [DEPTH-1:0]       fifo_valid;
    logic [DEPTH*AddrWidth-1:0] fifo_regs;
    wb_fifo #(.AW(AddrWidth), .W(width), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (src1_reg),
        .push_data (src1_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .ent_valid (fifo_valid),
        .ent_regs  (fifo_regs),
        .count     (pend_count)
    );
    function automatic logic pending(input logic [AddrWidth-1:0] r, input logic we,
                                     input logic [AddrWidth-1:0] wr, input logic [DEPTH-1:0] v,
                                     input logic [DEPTH*AddrWidth-1:0] regs);
        pending = we && wr == r;
        for (int i = 0; i < DEPTH; i++)
            pending |= v[i] && regs[i*AddrWidth +: AddrWidth] == r;
        pending &= r != ZERO;
    endfunction
    // Zero-register transfers still claim their slot but never write or queue.
    always_comb begin
        empty        = pend_count == '0;
        src1_ready   = pend_count != CW'(DEPTH);
        bypass       = !src0_valid && empty && src1_valid;
        pop          = !src0_valid && !empty;
        push         = src1_valid && src1_ready && !bypass && src1_reg != ZERO;
        sel_reg      = src0_valid ? src0_reg : pop ? head_reg : src1_reg;
        sel_data     = src0_valid ? src0_data : pop ? head_data : src1_data;
        reg_write_d  = src0_valid ? src0_reg != ZERO : pop ? 1'b1 : bypass && src1_reg != ZERO;
        write_reg_d  = reg_write_d ? sel_reg : write_reg_q;
        write_data_d = reg_write_d ? sel_data : write_data_q;
        hazard_a     = pending(chk_reg_a, reg_write_q, write_reg_q, fifo_valid, fifo_regs);
        hazard_b     = pending(chk_reg_b, reg_write_q, write_reg_q, fifo_valid, fifo_regs);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end
    assign RegWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus randomized run against a
// queue-based reference model of the write-back arbiter.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;
    localparam int D = 4;
    typedef struct packed {
        logic        rst;
        logic        s0v;
        logic [4:0]  s0r;
        logic [31:0] s0d;
        logic        s1v;
        logic [4:0]  s1r;
        logic [31:0] s1d;
        logic [4:0]  ca;
        logic [4:0]  cb;
    } in_t;
    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [2:0]  pend;
        logic        rdy;
        logic        ha;
        logic        hb;
    } out_t;
    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src0_valid = 1'b0, src1_valid = 1'b0, src1_ready;
    logic [4:0]  src0_reg = '0, src1_reg = '0, chk_reg_a = '0, chk_reg_b = '0, writeReg;
    logic [31:0] src0_data = '0, src1_data = '0, writeData;
    logic        RegWrite, hazard_a, hazard_b;
    logic [2:0]  pend_count;
    int          n_vec = 0, n_err = 0;
    vec_t        vq[$];
    wb_entry_t   mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;

    regfile_wb_arbiter #(.width(32), .AddrWidth(5), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .src0_valid(src0_valid), .src0_reg(src0_reg), .src0_data(src0_data),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_reg(src1_reg), .src1_data(src1_data),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .chk_reg_a(chk_reg_a), .chk_reg_b(chk_reg_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, s0v, input logic [4:0] s0r, input logic [31:0] s0d,
                       input logic s1v, input logic [4:0] s1r, input logic [31:0] s1d,
                       input logic [4:0] ca, cb, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [2:0] pd, input logic rdy, ha, hb);
        vec_t v;
        v.i = '{r, s0v, s0r, s0d, s1v, s1r, s1d, ca, cb};
        v.e = '{we, wr, wd, pd, rdy, ha, hb};
        vq.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst = i.rst;
        src0_valid = i.s0v; src0_reg = i.s0r; src0_data = i.s0d;
        src1_valid = i.s1v; src1_reg = i.s1r; src1_data = i.s1d;
        chk_reg_a = i.ca; chk_reg_b = i.cb;
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = '{RegWrite, writeReg, writeData, pend_count, src1_ready, hazard_a, hazard_b};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got we=%0d reg=%0d data=%h pend=%0d rdy=%0d ha=%0d hb=%0d, want we=%0d reg=%0d data=%h pend=%0d rdy=%0d ha=%0d hb=%0d",
                     name, a.we, a.wreg, a.wdata, a.pend, a.rdy, a.ha, a.hb,
                     e.we, e.wreg, e.wdata, e.pend, e.rdy, e.ha, e.hb);
        end
    endtask

    function automatic logic m_haz(input logic [4:0] c);
        if (c == 0) return 1'b0;
        if (m_we && m_reg == c) return 1'b1;
        foreach (mq[k]) if (mq[k].wreg == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic out_t model_out(input logic [4:0] ca, cb);
        out_t o;
        o.we = m_we; o.wreg = m_reg; o.wdata = m_data;
        o.pend = 3'(mq.size());
        o.rdy = mq.size() != D;
        o.ha = m_haz(ca); o.hb = m_haz(cb);
        return o;
    endfunction

    // Advance the model by one clock edge given the inputs seen at that edge.
    function automatic void model_step(input in_t i);
        int n;
        logic take1, byp;
        wb_entry_t e;
        n = mq.size();
        take1 = i.s1v && n != D;
        byp = 1'b0;
        if (i.rst) begin
            mq.delete(); m_we = 1'b0; m_reg = '0; m_data = '0;
            return;
        end
        if (i.s0v) begin
            m_we = i.s0r != 0;
            if (m_we) begin m_reg = i.s0r; m_data = i.s0d; end
        end else if (n > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_reg = e.wreg; m_data = e.data;
        end else if (i.s1v) begin
            byp = 1'b1;
            m_we = i.s1r != 0;
            if (m_we) begin m_reg = i.s1r; m_data = i.s1d; end
        end else
            m_we = 1'b0;
        if (take1 && !byp && i.s1r != 0) mq.push_back('{i.s1r, i.s1d});
    endfunction

    initial begin
        in_t ri;
        //  rst s0v s0r s0d        s1v s1r s1d        ca  cb   we wr  wd         pd rdy ha hb
        add(1, 0, 0,  0,         0, 0,  0,         0,  0,   0, 0,  0,         0, 1, 0, 0);
        add(1, 0, 0,  0,         0, 0,  0,         0,  0,   0, 0,  0,         0, 1, 0, 0);
        add(0, 0, 0,  0,         0, 0,  0,         0,  0,   0, 0,  0,         0, 1, 0, 0);
        add(0, 0, 0,  0,         1, 5,  'h1234,    5,  0,   1, 5,  'h1234,    0, 1, 1, 0);
        add(0, 0, 0,  0,         0, 0,  0,         5,  0,   0, 5,  'h1234,    0, 1, 0, 0);
        add(0, 1, 3,  'hAAAA,    1, 7,  'hBBBB,    7,  3,   1, 3,  'hAAAA,    1, 1, 1, 1);
        add(0, 0, 0,  0,         0, 0,  0,         7,  3,   1, 7,  'hBBBB,    0, 1, 1, 0);
        add(0, 0, 0,  0,         0, 0,  0,         7,  3,   0, 7,  'hBBBB,    0, 1, 0, 0);
        add(0, 1, 20, 'h100,     1, 8,  'h800,     8,  12,  1, 20, 'h100,     1, 1, 1, 0);
        add(0, 1, 21, 'h101,     1, 9,  'h900,     8,  12,  1, 21, 'h101,     2, 1, 1, 0);
        add(0, 1, 22, 'h102,     1, 10, 'hA00,     8,  12,  1, 22, 'h102,     3, 1, 1, 0);
        add(0, 1, 23, 'h103,     1, 11, 'hB00,     8,  12,  1, 23, 'h103,     4, 0, 1, 0);
        add(0, 1, 24, 'h104,     1, 12, 'hC00,     8,  12,  1, 24, 'h104,     4, 0, 1, 0);
        add(0, 1, 25, 'h105,     1, 12, 'hC00,     8,  12,  1, 25, 'h105,     4, 0, 1, 0);
        add(0, 0, 0,  0,         1, 12, 'hC00,     8,  12,  1, 8,  'h800,     3, 1, 1, 0);
        add(0, 0, 0,  0,         1, 12, 'hC00,     8,  12,  1, 9,  'h900,     3, 1, 0, 1);
        add(0, 0, 0,  0,         0, 0,  0,         8,  12,  1, 10, 'hA00,     2, 1, 0, 1);
        add(0, 0, 0,  0,         0, 0,  0,         8,  12,  1, 11, 'hB00,     1, 1, 0, 1);
        add(0, 0, 0,  0,         0, 0,  0,         8,  12,  1, 12, 'hC00,     0, 1, 0, 1);
        add(0, 0, 0,  0,         0, 0,  0,         8,  12,  0, 12, 'hC00,     0, 1, 0, 0);
        add(0, 1, 0,  'hFFFF,    0, 0,  0,         0,  0,   0, 12, 'hC00,     0, 1, 0, 0);
        add(0, 0, 0,  0,         1, 0,  'hEEEE,    0,  0,   0, 12, 'hC00,     0, 1, 0, 0);
        add(0, 1, 1,  'h11,      1, 14, 'hE00,     14, 16,  1, 1,  'h11,      1, 1, 1, 0);
        add(0, 1, 2,  'h22,      1, 15, 'hF00,     14, 16,  1, 2,  'h22,      2, 1, 1, 0);
        add(0, 1, 3,  'h33,      1, 16, 'h1600,    14, 16,  1, 3,  'h33,      3, 1, 1, 1);
        add(1, 0, 0,  0,         0, 0,  0,         14, 16,  0, 0,  0,         0, 1, 0, 0);
        add(0, 0, 0,  0,         0, 0,  0,         14, 16,  0, 0,  0,         0, 1, 0, 0);
        add(0, 0, 0,  0,         0, 0,  0,         14, 16,  0, 0,  0,         0, 1, 0, 0);
        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].i);
            @(posedge clk);
            #1 check($sformatf("vec%0d", k), vq[k].e);
        end
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            ri.rst = n == 0 || $urandom_range(0, 59) == 0;
            ri.s0v = $urandom_range(0, 2) == 0;
            ri.s0r = 5'($urandom_range(0, 7));
            ri.s0d = $urandom;
            ri.s1v = $urandom_range(0, 3) != 0;
            ri.s1r = 5'($urandom_range(0, 7));
            ri.s1d = $urandom;
            ri.ca  = 5'($urandom_range(0, 7));
            ri.cb  = 5'($urandom_range(0, 7));
            drive(ri);
            model_step(ri);
            @(posedge clk);
            #1 check($sformatf("rand%0d", n), model_out(ri.ca, ri.cb));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
